auto_counter_bank: RTL and testbench
====================================

Name: auto_counter_bank

Overview:
- Bank of CHANNELS independent auto-stopping counters, each WIDTH bits wide.
- Each channel starts on a start pulse and counts up by one per clock to a programmable terminal value.
- At the terminal value a channel either stops (one-shot) or reloads to 0 (periodic).
- Used as the timer/sequencing source for control FSMs that need several concurrent delays.

Parameters:
- WIDTH, 4: counter and limit width per channel (>=1).
- CHANNELS, 2: number of independent channels (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  CHANNELS  per-channel start/restart pulse.
- abort  in  CHANNELS  per-channel stop without completion.
- periodic  in  CHANNELS  per-channel mode, sampled at start: 0 = one-shot, 1 = periodic.
- limit  in  CHANNELS*WIDTH  per-channel terminal count; channel i uses bits [i*WIDTH +: WIDTH]; sampled at start.
- count  out  CHANNELS*WIDTH  per-channel current count, same packing as limit.
- busy  out  CHANNELS  channel in RUN state.
- done  out  CHANNELS  one-cycle pulse when the terminal count is reached.
- irq  out  1  sticky OR of completions (see Optional Feature).
- irq_clear  in  1  clears sticky completion flags.

Behaviour:
- Reset (synchronous, active-high, per channel):
  - state=IDLE, count=0, busy=0, done=0, latched limit=0, latched mode=0, irq=0.
  - Reset has priority over every other input, including mid-run; no done pulse is produced.
- States per channel: IDLE, RUN. busy is the registered value of (state==RUN).
- IDLE:
  - start=1 -> RUN; count<=0; latch limit and periodic.
  - abort=1 alone -> no effect.
- RUN, evaluated in priority order:
  - abort=1 -> IDLE; count holds its value; no done. abort beats a simultaneous start or terminal event.
  - else start=1 -> restart: count<=0, re-latch limit and mode, no done, stay RUN.
  - else if count==latched limit:
    - done<=1 for exactly one cycle.
    - one-shot: -> IDLE, count holds at limit.
    - periodic: count<=0, stay RUN.
  - else count<=count+1.
- Timing: with start on edge 0 and limit L:
  - count reads 0..L on cycles 1..L+1; done is high on cycle L+2.
  - one-shot: busy is high on cycles 1..L+1 and drops on cycle L+2.
  - periodic: done repeats every L+1 cycles.
- limit=0: one-shot gives done 2 cycles after start; periodic gives done every cycle from cycle 2 on.
- Arithmetic: count never exceeds the latched limit, so there is no wrap. limit = 2^WIDTH-1 is legal and reaches all-ones before completing.
- Changes to limit/periodic during RUN are ignored until the next start.
- Channels are fully independent; no shared state except irq.
- done is combinationally independent of inputs (registered output).

Optional Feature:
- Macro: AUTO_COUNTER_IRQ_EN.
- With the macro defined:
  - Each channel has a sticky flag, set on its done and cleared by irq_clear.
  - If done and irq_clear coincide, set wins.
  - irq = registered OR of all flags, so irq rises 1 cycle after done.
- Without the macro: flags are not built, irq is tied 0, and irq_clear is ignored. The port list is unchanged.

Decomposition:
- Package auto_counter_pkg:
  - typedef enum logic {IDLE, RUN} ac_state_t.
  - typedef enum logic {ONE_SHOT, PERIODIC} ac_mode_t.
  - localparam defaults for WIDTH and CHANNELS.
- Sub-module auto_counter_channel (parameter WIDTH):
  - Ports: clk, reset, start, abort, periodic, limit, count, busy, done.
  - One instance per channel via generate.
  - Sticky flags and the irq OR live in the top level.

Test Plan:
- Reset mid-run: channel 0 running with limit=9, count=4, assert reset 1 cycle -> count=0, busy=0, no done, irq=0.
- One-shot, WIDTH=4, limit=5: start pulse -> count 0..5 over 6 cycles, done high 1 cycle, busy=0, count holds 5.
- Periodic, limit=3:
  - start -> done every 4 cycles for 3 periods, with count sequence 0,1,2,3,0.
  - Change limit to 7 mid-run -> period stays 4.
- Restart and abort:
  - start again at count=2 (limit=6) -> count back to 0, done 7 cycles later.
  - start and abort in the same cycle -> IDLE, count frozen, no done.
- Edge limits:
  - limit=0 one-shot -> done 2 cycles after start.
  - limit=15 (WIDTH=4) -> reaches 15, no wrap, single done.
  - Two channels run with limits 2 and 5 concurrently -> independent done pulses.
- AUTO_COUNTER_IRQ_EN:
  - With the macro: done -> irq=1 next cycle; irq_clear together with a new done keeps irq=1; irq_clear alone -> irq=0.
  - Without the macro: irq stays 0 throughout.

Source files
------------

// File: rtl/auto_counter_pkg.sv
// -----------------------------------------------------------------------------
// auto_counter_pkg
//   Shared types and default sizes for the auto-stopping counter bank.
//
//   ac_state_t  : per-channel control state (IDLE / RUN)
//   ac_mode_t   : completion behaviour latched at start (ONE_SHOT / PERIODIC)
//   AC_WIDTH    : default counter/limit width per channel
//   AC_CHANNELS : default number of channels
// -----------------------------------------------------------------------------
package auto_counter_pkg;

  localparam int AC_WIDTH    = 4;
  localparam int AC_CHANNELS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ac_state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } ac_mode_t;

  // Map the raw periodic input bit onto the mode enum.
  function automatic ac_mode_t ac_mode_of(input logic periodic);
    return periodic ? PERIODIC : ONE_SHOT;
  endfunction

endpackage

// File: rtl/auto_counter_channel.sv
// -----------------------------------------------------------------------------
// auto_counter_channel
//   One auto-stopping counter. A start pulse latches limit/mode and counts
//   0..limit, one step per clock. On reaching the latched limit it pulses done
//   for one cycle and either stops (one-shot) or reloads to 0 (periodic).
//   abort returns to IDLE with the count frozen and no done.
//
// Parameters:
//   WIDTH    counter and limit width
// Ports:
//   clk      clock, all state on posedge
//   reset    synchronous active-high reset
//   start    start / restart pulse (re-latches limit and mode)
//   abort    stop without completion (wins over start and terminal)
//   periodic mode at start: 0 one-shot, 1 periodic
//   limit    terminal count, sampled at start
//   count    current count
//   busy     channel is in RUN
//   done     registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module auto_counter_channel
  import auto_counter_pkg::*;
#(
  parameter int WIDTH = AC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  // Configuration captured at start; ignored inputs during RUN live here.
  typedef struct packed {
    logic [WIDTH-1:0] limit;
    ac_mode_t         mode;
  } cfg_t;

  ac_state_t state, state_nxt;
  cfg_t      cfg_q;
  logic      load;   // start accepted: clear count, latch config
  logic      term;   // terminal count reached in RUN, no override
  logic      incr;   // ordinary count step
  logic      at_lim;

  assign at_lim = (count == cfg_q.limit);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control, priority abort > start > terminal > step
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    term      = 1'b0;
    incr      = 1'b0;
    case (state)
      IDLE: begin
        // abort alone in IDLE has no effect
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          load = 1'b1;
        end else if (at_lim) begin
          term = 1'b1;
          if (cfg_q.mode == ONE_SHOT) state_nxt = IDLE;
        end else begin
          incr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    busy = (state == RUN);
  end

  // Count, latched config and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      cfg_q <= '{limit: '0, mode: ONE_SHOT};
      done  <= 1'b0;
    end else begin
      done <= term;
      if (load) begin
        count       <= '0;
        cfg_q.limit <= limit;
        cfg_q.mode  <= ac_mode_of(periodic);
      end else if (term) begin
        // one-shot holds at the limit; periodic reloads
        if (cfg_q.mode == PERIODIC) count <= '0;
      end else if (incr) begin
        // count never exceeds the latched limit, so this cannot wrap
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/auto_counter_bank.sv
// -----------------------------------------------------------------------------
// auto_counter_bank
//   CHANNELS independent auto-stopping counters plus a shared completion irq.
//
//   Optional feature macro: AUTO_COUNTER_IRQ_EN
//     defined   : per-channel sticky flags set by done, cleared by irq_clear
//                 (set wins); irq is the registered OR, rising one cycle
//                 after done.
//     undefined : no flags, irq tied 0, irq_clear ignored.
//
// Parameters:
//   WIDTH     counter/limit width per channel
//   CHANNELS  number of channels
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start/abort         per-channel start/restart and stop pulses
//   periodic            per-channel mode, sampled at start
//   limit               per-channel terminal count, channel i at [i*WIDTH +: WIDTH]
//   count               per-channel count, same packing as limit
//   busy, done          per-channel RUN status and completion pulse
//   irq, irq_clear      sticky completion interrupt and its clear
// -----------------------------------------------------------------------------
module auto_counter_bank
  import auto_counter_pkg::*;
#(
  parameter int WIDTH    = AC_WIDTH,
  parameter int CHANNELS = AC_CHANNELS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] limit,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic                      irq,
  input  logic                      irq_clear
);

  // Packed per-lane views; element i occupies bits [i*WIDTH +: WIDTH].
  logic [CHANNELS-1:0][WIDTH-1:0] lim_v;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_v;

  assign lim_v = limit;
  assign count = cnt_v;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    auto_counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .abort    (abort[g]),
      .periodic (periodic[g]),
      .limit    (lim_v[g]),
      .count    (cnt_v[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

`ifdef AUTO_COUNTER_IRQ_EN
  logic [CHANNELS-1:0] flags, flags_nxt;

  // Set has priority over clear when both land on the same cycle.
  always_comb begin
    flags_nxt = done | (flags & {CHANNELS{~irq_clear}});
  end

  // irq follows flags_nxt so it rises on the edge that first sees done.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= flags_nxt;
      irq   <= |flags_nxt;
    end
  end
`else
  logic unused_irq_clear;
  assign unused_irq_clear = irq_clear;
  assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_auto_counter_bank.sv
module tb_auto_counter_bank;
  localparam int W = 4;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   start, abort, periodic;
  logic [C*W-1:0] limit, count;
  logic [C-1:0]   busy, done;
  logic           irq, irq_clear;

  int tests_run    = 0;
  int tests_failed = 0;

  auto_counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .periodic(periodic), .limit(limit), .count(count), .busy(busy),
    .done(done), .irq(irq), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  // Pulse start on one channel; afterwards we sit in cycle 1 (count 0).
  task automatic launch(input int ch, input logic [W-1:0] lim, input logic per);
    limit[ch*W +: W] = lim;
    periodic[ch]     = per;
    start[ch]        = 1'b1;
    tick();
    start[ch]        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count got=%h exp=0", count); end
    tests_run++; if (busy !== '0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== '0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got=%b exp=0", irq); end
    // reset in the middle of a run
    launch(0, 4'd9, 1'b0);
    repeat (4) tick();
    tests_run++; if (cnt(0) !== 4'd4) begin tests_failed++; $display("FAIL midrun_pre count=%0d exp=4", cnt(0)); end
    reset = 1'b1; tick(); reset = 1'b0;
    tests_run++; if (cnt(0) !== 4'd0) begin tests_failed++; $display("FAIL midrun_count got=%0d exp=0", cnt(0)); end
    tests_run++; if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL midrun_busy got=%b exp=0", busy[0]); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL midrun_irq got=%b exp=0", irq); end
    for (int i = 0; i < 12; i++) begin
      tests_run++; if (done !== '0 || busy !== '0) begin tests_failed++; $display("FAIL midrun_quiet cyc=%0d done=%b busy=%b exp=00/00", i, done, busy); end
      tick();
    end
  endtask

  task automatic test_one_shot();
    launch(0, 4'd5, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      tests_run++; if (cnt(0) !== W'(i) || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
        tests_failed++; $display("FAIL oneshot_run i=%0d count=%0d busy=%b done=%b exp=%0d/1/0", i, cnt(0), busy[0], done[0], i);
      end
      tick();
    end
    tests_run++; if (done[0] !== 1'b1 || busy[0] !== 1'b0 || cnt(0) !== 4'd5) begin
      tests_failed++; $display("FAIL oneshot_done done=%b busy=%b count=%0d exp=1/0/5", done[0], busy[0], cnt(0));
    end
    tick();
    tests_run++; if (done[0] !== 1'b0 || cnt(0) !== 4'd5) begin
      tests_failed++; $display("FAIL oneshot_hold done=%b count=%0d exp=0/5", done[0], cnt(0));
    end
  endtask

  task automatic test_periodic();
    launch(0, 4'd3, 1'b1);
    for (int c = 1; c <= 13; c++) begin
      logic [W-1:0] ec;
      logic         ed;
      ec = W'((c - 1) % 4);
      ed = (c >= 5) && ((c - 5) % 4 == 0);
      tests_run++; if (cnt(0) !== ec || done[0] !== ed || busy[0] !== 1'b1) begin
        tests_failed++; $display("FAIL periodic cyc=%0d count=%0d done=%b busy=%b exp=%0d/%b/1", c, cnt(0), done[0], busy[0], ec, ed);
      end
      if (c == 6) begin limit[W-1:0] = 4'd7; periodic[0] = 1'b0; end
      if (c < 13) tick();
    end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    tests_run++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      tests_failed++; $display("FAIL periodic_abort busy=%b done=%b exp=0/0", busy[0], done[0]);
    end
  endtask

  task automatic test_restart_abort();
    launch(0, 4'd6, 1'b0);
    tick(); tick();
    tests_run++; if (cnt(0) !== 4'd2) begin tests_failed++; $display("FAIL restart_pre count=%0d exp=2", cnt(0)); end
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    tests_run++; if (cnt(0) !== 4'd0 || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
      tests_failed++; $display("FAIL restart_zero count=%0d busy=%b done=%b exp=0/1/0", cnt(0), busy[0], done[0]);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests_run++; if (cnt(0) !== W'(k) || done[0] !== 1'b0) begin
        tests_failed++; $display("FAIL restart_run k=%0d count=%0d done=%b exp=%0d/0", k, cnt(0), done[0], k);
      end
    end
    tick();
    tests_run++; if (done[0] !== 1'b1 || cnt(0) !== 4'd6 || busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL restart_done done=%b count=%0d busy=%b exp=1/6/0", done[0], cnt(0), busy[0]);
    end
    // start and abort together while running: abort wins
    launch(0, 4'd6, 1'b0);
    repeat (3) tick();
    start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
    tests_run++; if (busy[0] !== 1'b0 || cnt(0) !== 4'd3 || done[0] !== 1'b0) begin
      tests_failed++; $display("FAIL start_abort busy=%b count=%0d done=%b exp=0/3/0", busy[0], cnt(0), done[0]);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++; if (done[0] !== 1'b0 || cnt(0) !== 4'd3) begin
        tests_failed++; $display("FAIL abort_frozen i=%0d done=%b count=%0d exp=0/3", i, done[0], cnt(0));
      end
    end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    tests_run++; if (busy[0] !== 1'b0 || cnt(0) !== 4'd3) begin
      tests_failed++; $display("FAIL idle_abort busy=%b count=%0d exp=0/3", busy[0], cnt(0));
    end
  endtask

  task automatic test_edge_limits();
    launch(0, 4'd0, 1'b0);
    tests_run++; if (busy[0] !== 1'b1 || done[0] !== 1'b0 || cnt(0) !== 4'd0) begin
      tests_failed++; $display("FAIL lim0_c1 busy=%b done=%b count=%0d exp=1/0/0", busy[0], done[0], cnt(0));
    end
    tick();
    tests_run++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL lim0_done done=%b busy=%b exp=1/0", done[0], busy[0]);
    end
    tick();
    tests_run++; if (done[0] !== 1'b0) begin tests_failed++; $display("FAIL lim0_once done=%b exp=0", done[0]); end
    // full-scale limit
    launch(0, 4'd15, 1'b0);
    for (int i = 0; i <= 15; i++) begin
      tests_run++; if (cnt(0) !== W'(i) || done[0] !== 1'b0 || busy[0] !== 1'b1) begin
        tests_failed++; $display("FAIL lim15_run i=%0d count=%0d done=%b busy=%b exp=%0d/0/1", i, cnt(0), done[0], busy[0], i);
      end
      tick();
    end
    tests_run++; if (done[0] !== 1'b1 || cnt(0) !== 4'd15 || busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL lim15_done done=%b count=%0d busy=%b exp=1/15/0", done[0], cnt(0), busy[0]);
    end
    tick();
    tests_run++; if (done[0] !== 1'b0 || cnt(0) !== 4'd15) begin
      tests_failed++; $display("FAIL lim15_hold done=%b count=%0d exp=0/15", done[0], cnt(0));
    end
    // periodic limit 0 on channel 1: done every cycle from cycle 2
    launch(1, 4'd0, 1'b1);
    tests_run++; if (done[1] !== 1'b0) begin tests_failed++; $display("FAIL plim0_c1 done=%b exp=0", done[1]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (done[1] !== 1'b1 || cnt(1) !== 4'd0) begin
        tests_failed++; $display("FAIL plim0_run i=%0d done=%b count=%0d exp=1/0", i, done[1], cnt(1));
      end
    end
    abort[1] = 1'b1; tick(); abort[1] = 1'b0;
    tests_run++; if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
      tests_failed++; $display("FAIL plim0_abort done=%b busy=%b exp=0/0", done[1], busy[1]);
    end
  endtask

  task automatic test_concurrent();
    limit = {4'd5, 4'd2}; periodic = 2'b00;
    start = 2'b11; tick(); start = 2'b00;
    for (int c = 1; c <= 9; c++) begin
      logic [W-1:0] e0, e1;
      logic [C-1:0] ed;
      e0 = (c - 1 < 2) ? W'(c - 1) : 4'd2;
      e1 = (c - 1 < 5) ? W'(c - 1) : 4'd5;
      ed = {c == 7, c == 4};
      tests_run++; if (cnt(0) !== e0 || cnt(1) !== e1 || done !== ed) begin
        tests_failed++; $display("FAIL concurrent cyc=%0d c0=%0d c1=%0d done=%b exp=%0d/%0d/%b", c, cnt(0), cnt(1), done, e0, e1, ed);
      end
      tick();
    end
  endtask

  task automatic test_irq();
`ifdef AUTO_COUNTER_IRQ_EN
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_cleared got=%b exp=0", irq); end
    launch(0, 4'd1, 1'b0);
    tick(); tick();
    tests_run++; if (done[0] !== 1'b1 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_done_cyc done=%b irq=%b exp=1/0", done[0], irq);
    end
    tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_rise got=%b exp=1", irq); end
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clear1 got=%b exp=0", irq); end
    // clear coincident with a fresh done: set wins
    launch(0, 4'd1, 1'b1);
    tick(); tick();
    tests_run++; if (done[0] !== 1'b1 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_p_done done=%b irq=%b exp=1/0", done[0], irq);
    end
    irq_clear = 1'b1; tick();
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    abort[0] = 1'b1; tick(); abort[0] = 1'b0; irq_clear = 1'b0;
    tests_run++; if (irq !== 1'b0 || busy[0] !== 1'b0) begin
      tests_failed++; $display("FAIL irq_clear2 irq=%b busy=%b exp=0/0", irq, busy[0]);
    end
    tick();
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_stays0 got=%b exp=0", irq); end
`else
    launch(0, 4'd1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      irq_clear = (c == 3);
      tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_tied cyc=%0d got=%b exp=0", c, irq); end
      tick();
    end
    irq_clear = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1; start = '0; abort = '0; periodic = '0; limit = '0; irq_clear = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic();
    test_restart_abort();
    test_edge_limits();
    test_concurrent();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
